// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command and result handshakes between a command source
// (master) and the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
  parameter int unsigned W = 4
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [W-1:0]   cmd_a;
  logic [W-1:0]   cmd_b;
  logic [1:0]     cmd_s;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_y;
  logic           res_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_s, res_ready,
    input  cmd_ready, res_valid, res_y, res_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_s, res_ready,
    output cmd_ready, res_valid, res_y, res_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU commands in a FIFO, issues them one at a time
// through registered operand outputs, captures the ALU result one cycle later
// and holds it until the downstream consumer accepts it.
// Optional divide-by-zero detection: define ALU_ISSUE_CTRL_DIVZ_CHECK_EN.
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_issue_ctrl_if.slave          bus,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [1:0]               alu_s,
  input  logic [2*W-1:0]           alu_y,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 2 * W + 2;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           res_valid_q;
  logic [2*W-1:0] res_y_q;

  assign full  = (fifo_count == (AW + 1)'(DEPTH));
  assign empty = (fifo_count == '0);
  assign push  = bus.cmd_valid && !full;
  // The head is consumed when idle, or in DONE on the same edge the held
  // result is handed off, which keeps one result every two cycles.
  assign pop   = !empty && ((state == IDLE) || ((state == DONE) && bus.res_ready));
  assign head  = mem[rd_ptr];

  assign bus.cmd_ready = !full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = res_y_q;
  assign busy          = (state != IDLE) || !empty;

`ifdef ALU_ISSUE_CTRL_DIVZ_CHECK_EN
  logic res_err_q;
  logic div_zero;
  assign div_zero    = (alu_s == 2'b11) && (alu_b == '0);
  assign bus.res_err = res_err_q;
`else
  assign bus.res_err = 1'b0;
`endif

  // Command storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_s, bus.cmd_b, bus.cmd_a};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue FSM: load operands, capture result, hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_s       <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
`ifdef ALU_ISSUE_CTRL_DIVZ_CHECK_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a <= head[W-1:0];
            alu_b <= head[2*W-1:W];
            alu_s <= head[CW-1:2*W];
            state <= EXEC;
          end
        end
        EXEC: begin
          res_valid_q <= 1'b1;
`ifdef ALU_ISSUE_CTRL_DIVZ_CHECK_EN
          if (div_zero) begin
            res_y_q   <= '1;
            res_err_q <= 1'b1;
          end else begin
            res_y_q   <= alu_y;
            res_err_q <= 1'b0;
          end
`else
          res_y_q <= alu_y;
`endif
          state <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              alu_a <= head[W-1:0];
              alu_b <= head[2*W-1:W];
              alu_s <= head[CW-1:2*W];
              state <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front/back end for the 4-bit combinational ALU (operands a, b; select s; 8-bit result y).
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the ALU through registered operand outputs, captures the ALU result one cycle later, and presents it downstream with valid/ready.
- Sits between the command source (bench or sequencer) and the ALU instance.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, minimum 2.
- W, 4, operand width; result width is 2*W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command; equals !full.
- cmd_a  input  W  operand a.
- cmd_b  input  W  operand b.
- cmd_s  input  2  op select: 00 add, 01 sub, 10 mul, 11 div.
- alu_a  output  W  registered operand a to ALU.
- alu_b  output  W  registered operand b to ALU.
- alu_s  output  2  registered select to ALU.
- alu_y  input  2*W  ALU result (combinational from alu_a/alu_b/alu_s).
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  downstream accepts the result.
- res_y  output  2*W  captured result.
- res_err  output  1  captured result was a divide by zero (see Optional Feature).
- fifo_count  output  log2(DEPTH)+1  FIFO occupancy.
- busy  output  1  high when state != IDLE or FIFO not empty.

Behaviour:
- Reset (async, rst=1): FIFO empty, fifo_count=0, state IDLE, alu_a/alu_b/alu_s=0, res_valid=0, res_y=0, res_err=0, busy=0.
- Reset mid-operation discards all queued and in-flight commands; no result is emitted.
- Push: on a clk edge where cmd_valid && cmd_ready, {cmd_s, cmd_b, cmd_a} is written at the write pointer.
  - Pointers wrap modulo DEPTH.
  - cmd_ready is !full only; when full, no push occurs even if a pop happens in the same cycle.
- FSM states IDLE, EXEC, DONE:
  - IDLE: if FIFO not empty, pop the head into alu_a/alu_b/alu_s and go to EXEC. Otherwise stay.
  - EXEC: ALU settles. At the edge, res_y <= alu_y, res_err per divide-by-zero rule, res_valid <= 1, go to DONE.
  - DONE: res_valid=1 and res_y stable until res_ready=1. On the handshake edge, res_valid <= 0. In the same edge, if FIFO not empty, pop the next command and go to EXEC; else go to IDLE.
- Push and pop in the same cycle: fifo_count is unchanged; both operations take effect.
- Latency: command accepted at edge N, popped at N+1, res_valid high after edge N+2. Back-to-back throughput is one result per 2 cycles with res_ready held high.
- alu_a/alu_b/alu_s hold their last values outside EXEC (no toggling while idle).
- Arithmetic is performed by the ALU, not this block. Widths are unsigned, 2*W-bit results; sub wraps, e.g. 1-3 = 8'hFE.

Optional Feature:
- Macro: ALU_ISSUE_CTRL_DIVZ_CHECK_EN.
- Defined: in EXEC, if alu_s==2'b11 and alu_b==0, res_y <= {2*W{1'b1}} (8'hFF) and res_err <= 1. Otherwise res_err <= 0.
- Not defined: res_err is tied to 0 and res_y <= alu_y unconditionally, so a divide by zero passes the ALU output through.

Test Plan:
- Single add: cmd a=1, b=3, s=00 at edge 0 -> res_valid high after edge 2, res_y=8'h04, res_err=0; res_ready=1 clears res_valid next edge.
- Sequence sub/mul/div: (3,1,01), (4,2,10), (2,1,11) pushed back-to-back, res_ready=1 -> results 8'h02, 8'h08, 8'h02 in order, spaced 2 cycles apart; fifo_count peaks at 2 and returns to 0.
- Backpressure and full: res_ready=0, push DEPTH+2 commands -> cmd_ready drops after 5 accepted (1 in result + 4 in FIFO). Results come out in order once res_ready=1, with no loss or duplication.
- Divide by zero, macro defined: (5,0,11) -> res_y=8'hFF, res_err=1. Macro undefined: res_err=0, res_y=alu_y.
- Reset mid-operation: assert rst in EXEC with 3 queued -> res_valid=0, fifo_count=0, busy=0 immediately; after release, a new cmd (2,2,00) yields 8'h04.
- Wrap-around: 3*DEPTH mixed commands with random res_ready -> results match the reference model for every op, pointers wrap correctly.
